parity_stream_codec: RTL and testbench
======================================

Name: parity_stream_codec

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational odd-parity generator.
- Accepts a valid/ready stream of DATA_W-bit words and, per word, either generates a parity bit (generate mode) or checks a received one (check mode), selectable as odd or even parity.
- Accumulates parity across fixed-length frames of FRAME_LEN words.
- Sits between a data source and a serial/link packer.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- FRAME_LEN, 4, words per frame (>=1).
- ODD, 1, 1 = odd parity (total ones including parity bit is odd); 0 = even parity.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = generate, 1 = check; sampled only on the first word of a frame
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word
- s_data  in  DATA_W  input word
- s_par  in  1  received parity bit; used in check mode only
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the output word
- m_data  out  DATA_W+1  {parity_bit, data}; parity is computed in generate mode, passed from s_par in check mode
- m_err  out  1  check mode: parity mismatch on the word in m_data; 0 in generate mode
- frame_done  out  1  one-cycle pulse when the last word of a frame is loaded into the output register
- frame_par  out  1  parity bit (per ODD) over all FRAME_LEN*DATA_W data bits of the last completed frame; held until the next frame_done
- err_cnt  out  CNT_W  saturating count of m_err events (see Optional Feature)

Behaviour:
- Reset values: m_valid=0, m_data=0, m_err=0, frame_done=0, frame_par=0, err_cnt=0, frame counter=0, running accumulator=0, latched mode=0. s_ready=1 in the cycle after reset.
- Word parity: p = ^s_data ^ ODD. With ODD=1, p = ~^s_data.
- Handshake and pipeline:
  - s_ready = !m_valid || m_ready (single-stage register, combinational ready).
  - Accept = s_valid && s_ready; the accepted word appears on m_data at the next edge (latency 1).
  - Output is held stable while m_valid && !m_ready.
  - m_valid drops after a handshake with no new accept in the same cycle.
  - Simultaneous output handshake and new accept: m_valid stays 1 and m_data is replaced, giving full throughput.
- Frame state machine: FIRST (count==0) -> MID (0<count<FRAME_LEN-1) -> LAST (count==FRAME_LEN-1) -> FIRST. State advances only on accept.
  - FIRST: latch mode; clear the accumulator to this word's XOR.
  - MID: accumulator ^= ^s_data.
  - LAST: frame_par <= accumulator ^ ^s_data ^ ODD; pulse frame_done; counter wraps to 0.
  - FRAME_LEN=1: every accept is both FIRST and LAST; mode is latched and frame_done pulses on every word.
- Mode: changes on the mode port mid-frame are ignored until the next FIRST word. All words of a frame use the latched mode.
- Check mode: m_data = {s_par, s_data}; m_err = (s_par != p). m_err is registered alongside m_data and is valid only while m_valid=1.
- err_cnt increments by 1 on each accepted word with a mismatch and saturates at 2^CNT_W-1 with no wrap.
- Reset mid-frame: the partial frame is discarded, any pending output word is dropped, and the next accepted word is FIRST.
- No X propagation from s_data while s_valid=0: registers update only on accept.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: err_cnt behaves as described above.
- Undefined: no counter register is built, and err_cnt is tied to 0. All other behaviour is identical.

Test Plan (DATA_W=8, FRAME_LEN=4, ODD=1, m_ready=1 unless stated):
- Reset: assert rst for 2 cycles -> all outputs 0, s_ready=1 the cycle after rst deasserts.
- Generate frame: mode=0, send 0x00, 0x01, 0xFF, 0x07 back-to-back -> m_data = 9'h100, 9'h001, 9'h1FF, 9'h007, each one cycle after accept. frame_done pulses once with the 9'h007 word; frame_par=1 (12 ones total).
- Backpressure: hold m_ready=0 for 3 cycles with s_valid=1 -> s_ready=0, m_data unchanged, no words lost. Release m_ready -> the next word follows in the next cycle.
- Check mode and errors: mode=1, send 0x03/s_par=1 then 0x03/s_par=0 -> m_err=0 then 1; err_cnt=1 (macro defined) or 0 (macro undefined). Toggle mode mid-frame -> words stay in check mode until the frame ends.
- Reset mid-frame: accept 2 words, pulse rst, then accept 4 words -> frame_done pulses only on the 4th post-reset word.
- Saturation: CNT_W=2, send 5 bad-parity words -> err_cnt sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/parity_stream_codec.sv
// parity_stream_codec
//   Pipelined, parametrised parity generator/checker on a valid/ready stream.
//   In generate mode each word leaves with a freshly computed parity bit.
//   In check mode the received parity bit is passed through and flagged
//   when it disagrees with the data. Parity is also accumulated over
//   fixed frames of FRAME_LEN words. The mode is latched on the first
//   word of each frame.
//
//   Optional feature macro: PARITY_ERR_CNT_EN
//     defined   -> saturating error counter drives err_cnt
//     undefined -> no counter register is built; err_cnt is tied to 0
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   mode            0 = generate, 1 = check (sampled on first word of a frame)
//   s_valid/s_ready input handshake; s_data word, s_par received parity bit
//   m_valid/m_ready output handshake; m_data = {parity_bit, data}
//   m_err           check-mode parity mismatch for the word in m_data
//   frame_done      one-cycle pulse when a frame's last word is registered
//   frame_par       parity over the whole last completed frame
//   err_cnt         saturating count of mismatching accepted words
module parity_stream_codec #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_par,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W:0]   m_data,
  output logic              m_err,
  output logic              frame_done,
  output logic              frame_par,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic ODD_B = (ODD != 0);

  // Position of the current word within its frame, decoded from the counter.
  typedef enum logic [1:0] {
    PH_FIRST,
    PH_MID,
    PH_LAST,
    PH_SINGLE
  } phase_e;

  logic [CW-1:0]   count_q, count_d;
  logic            acc_q, acc_d;
  logic            mode_q, mode_d;
  logic            m_valid_q, m_valid_d;
  logic [DATA_W:0] m_data_q, m_data_d;
  logic            m_err_q, m_err_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_par_q, frame_par_d;

  phase_e phase;
  logic   accept;
  logic   word_x;
  logic   word_p;
  logic   eff_mode;
  logic   mismatch;

  assign s_ready  = !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;
  assign word_x   = ^s_data;
  assign word_p   = word_x ^ ODD_B;

  always_comb begin
    phase = PH_MID;
    if (count_q == '0 && count_q == LAST_CNT) phase = PH_SINGLE;
    else if (count_q == '0)                   phase = PH_FIRST;
    else if (count_q == LAST_CNT)             phase = PH_LAST;
  end

  // A new frame takes the live mode pin; later words reuse the latched mode.
  assign eff_mode = (phase == PH_FIRST || phase == PH_SINGLE) ? mode : mode_q;
  assign mismatch = eff_mode && (s_par != word_p);

  always_comb begin
    count_d      = count_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_err_d      = m_err_q;
    frame_done_d = 1'b0;
    frame_par_d  = frame_par_q;

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = {(eff_mode ? s_par : word_p), s_data};
      m_err_d   = mismatch;

      case (phase)
        PH_FIRST: begin
          mode_d  = mode;
          acc_d   = word_x;
          count_d = count_q + CW'(1);
        end
        PH_MID: begin
          acc_d   = acc_q ^ word_x;
          count_d = count_q + CW'(1);
        end
        PH_LAST: begin
          frame_par_d  = acc_q ^ word_x ^ ODD_B;
          frame_done_d = 1'b1;
          count_d      = '0;
        end
        default: begin
          // Single-word frames: first and last at once.
          mode_d       = mode;
          acc_d        = word_x;
          frame_par_d  = word_p;
          frame_done_d = 1'b1;
          count_d      = '0;
        end
      endcase
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      acc_q        <= 1'b0;
      mode_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_err_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_par_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_err_q      <= m_err_d;
      frame_done_q <= frame_done_d;
      frame_par_q  <= frame_par_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counter sticks at all-ones rather than wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_err      = m_err_q;
  assign frame_done = frame_done_q;
  assign frame_par  = frame_par_q;

endmodule

// File: tb/tb_parity_stream_codec.sv
// Testbench for parity_stream_codec: directed scenarios plus a randomized
// run, all checked against a behavioural model that counts ones per word
// and per frame.
module tb_parity_stream_codec;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 4;
  localparam int ODD       = 1;
  localparam int CNT_W     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_par;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W:0]   m_data;
  logic              m_err;
  logic              frame_done;
  logic              frame_par;
  logic [CNT_W-1:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  // Model state, describing the DUT after the most recent edge.
  bit              exp_valid;
  logic [DATA_W:0] exp_data;
  bit              exp_err;
  bit              exp_done;
  bit              exp_fpar;
  int              exp_cnt;
  int              word_idx;
  bit              frame_mode;
  int              frame_ones;

  parity_stream_codec #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ODD(ODD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_par(s_par),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .frame_done(frame_done), .frame_par(frame_par), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Parity bit that makes the ones count obey the ODD/EVEN rule.
  function automatic bit parityFor(input int ones);
    return bit'((ones + ODD) % 2);
  endfunction

  task automatic modelReset();
    exp_valid  = 0;
    exp_data   = '0;
    exp_err    = 0;
    exp_done   = 0;
    exp_fpar   = 0;
    exp_cnt    = 0;
    word_idx   = 0;
    frame_mode = 0;
    frame_ones = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check every output.
  task automatic applyStimulus(input bit r, input bit md, input bit v,
                               input logic [DATA_W-1:0] d, input bit pb, input bit rdy);
    bit ready;
    int ones;
    bit p;
    rst = r; mode = md; s_valid = v; s_data = d; s_par = pb; m_ready = rdy;
    #1;
    ready = !exp_valid || rdy;
    if (!r) checkOutput("s_ready", 32'(s_ready), 32'(ready));
    if (r) begin
      modelReset();
    end else if (v && ready) begin
      ones = $countones(d);
      if (word_idx == 0) begin
        frame_mode = md;
        frame_ones = 0;
      end
      frame_ones += ones;
      p = parityFor(ones);
      exp_valid = 1;
      exp_data  = {(frame_mode ? pb : p), d};
      exp_err   = frame_mode && (pb != p);
`ifdef PARITY_ERR_CNT_EN
      if (exp_err && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
      word_idx++;
      exp_done = 0;
      if (word_idx == FRAME_LEN) begin
        exp_done = 1;
        exp_fpar = parityFor(frame_ones);
        word_idx = 0;
      end
    end else begin
      exp_done = 0;
      if (rdy) exp_valid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("m_valid", 32'(m_valid), 32'(exp_valid));
    checkOutput("m_data", 32'(m_data), 32'(exp_data));
    checkOutput("m_err", 32'(m_err), 32'(exp_err));
    checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
    checkOutput("frame_par", 32'(frame_par), 32'(exp_fpar));
    checkOutput("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  function automatic int cntAfter(input int n);
`ifdef PARITY_ERR_CNT_EN
    return (n > 3) ? 3 : n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    rst = 1; mode = 0; s_valid = 0; s_data = '0; s_par = 0; m_ready = 1;
    modelReset();
    @(posedge clk); #1;

    // Reset for two cycles; outputs must be cleared and s_ready high after.
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    checkOutput("rst_m_data", 32'(m_data), 32'h0);
    #1 rst = 0;
    #1 checkOutput("rst_s_ready", 32'(s_ready), 32'h1);

    // Generate-mode frame.
    applyStimulus(0, 0, 1, 8'h00, 0, 1); checkOutput("gen_w0", 32'(m_data), 32'h100);
    applyStimulus(0, 0, 1, 8'h01, 0, 1); checkOutput("gen_w1", 32'(m_data), 32'h001);
    applyStimulus(0, 0, 1, 8'hFF, 0, 1); checkOutput("gen_w2", 32'(m_data), 32'h1FF);
    applyStimulus(0, 0, 1, 8'h07, 0, 1); checkOutput("gen_w3", 32'(m_data), 32'h007);
    checkOutput("gen_done", 32'(frame_done), 32'h1);
    checkOutput("gen_fpar", 32'(frame_par), 32'h1);

    // Backpressure: output held, input stalled, word follows on release.
    applyStimulus(0, 0, 1, 8'h55, 0, 1); checkOutput("bp_first", 32'(m_data), 32'h155);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 8'hAA, 0, 0);
      checkOutput("bp_hold", 32'(m_data), 32'h155);
      checkOutput("bp_s_ready", 32'(s_ready), 32'h0);
    end
    applyStimulus(0, 0, 1, 8'hAA, 0, 1); checkOutput("bp_release", 32'(m_data), 32'h1AA);

    // Check mode with a good then a bad word; mode toggles mid-frame are ignored.
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    applyStimulus(0, 1, 1, 8'h03, 1, 1); checkOutput("chk_ok", 32'(m_err), 32'h0);
    applyStimulus(0, 1, 1, 8'h03, 0, 1); checkOutput("chk_bad", 32'(m_err), 32'h1);
    checkOutput("chk_cnt", 32'(err_cnt), 32'(cntAfter(1)));
    applyStimulus(0, 0, 1, 8'h00, 0, 1); checkOutput("chk_latched", 32'(m_data), 32'h000);
    applyStimulus(0, 0, 1, 8'h00, 0, 1); checkOutput("chk_latched_err", 32'(m_err), 32'h1);

    // Reset mid-frame discards the partial frame.
    applyStimulus(0, 0, 1, 8'h11, 0, 1);
    applyStimulus(0, 0, 1, 8'h22, 0, 1);
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 8'(i * 37 + 5), 0, 1);
      checkOutput("mid_rst_done", 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
    end

    // Saturation of the 2-bit error counter.
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 1, 8'h03, 0, 1);
      checkOutput("sat_cnt", 32'(err_cnt), 32'(cntAfter(i)));
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                    8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
